// File: rtl/nios2_mul_pipe.sv
// Pipelined WIDTH x WIDTH integer multiplier covering mul/mulxss/mulxsu/mulxuu.
// Stage 1 registers four half-width partial products; the optional stage 2 registers the selected half.
module nios2_mul_pipe #(
   parameter int WIDTH = 32,
   parameter int PIPE  = 2,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_busy
);
   localparam int HALF = WIDTH / 2;
   localparam int PW   = 2 * WIDTH;

   localparam logic [1:0] MODE_MUL = 2'b00;
   localparam logic [1:0] MODE_XSS = 2'b01;
   localparam logic [1:0] MODE_XSU = 2'b10;

   // HALF x HALF product with optional per-operand sign; the true product always fits in WIDTH bits.
   function automatic logic [WIDTH-1:0] half_mul(input logic [HALF-1:0] a, input logic a_s,
                                                 input logic [HALF-1:0] b, input logic b_s);
      logic signed [WIDTH+1:0] ax;
      logic signed [WIDTH+1:0] bx;
      logic signed [WIDTH+1:0] pr;
      ax = signed'({{(HALF+2){a_s & a[HALF-1]}}, a});
      bx = signed'({{(HALF+2){b_s & b[HALF-1]}}, b});
      pr = ax * bx;
      return pr[WIDTH-1:0];
   endfunction

   function automatic logic [PW-1:0] ext(input logic [WIDTH-1:0] p, input logic s);
      return {{WIDTH{s & p[WIDTH-1]}}, p};
   endfunction

   function automatic logic [WIDTH-1:0] sel_result(input logic [WIDTH-1:0] p1, input logic [WIDTH-1:0] p2,
                                                   input logic [WIDTH-1:0] p3, input logic [WIDTH-1:0] p4,
                                                   input logic [1:0] mode);
      logic          a_s;
      logic          b_s;
      logic [PW-1:0] sum;
      a_s = (mode == MODE_XSS) || (mode == MODE_XSU);
      b_s = (mode == MODE_XSS);
      sum = (ext(p4, a_s | b_s) << WIDTH) + ((ext(p2, b_s) + ext(p3, a_s)) << HALF) + ext(p1, 1'b0);
      return (mode == MODE_MUL) ? sum[WIDTH-1:0] : sum[PW-1:WIDTH];
   endfunction

   logic             a_sgn;
   logic             b_sgn;
   logic             ld1;
   logic             accept;
   logic [WIDTH-1:0] p1_d, p2_d, p3_d, p4_d;
   logic [WIDTH-1:0] p1_q, p2_q, p3_q, p4_q;
   logic [1:0]       mode1_q;
   logic [TAG_W-1:0] tag1_q;
   logic             v1_q;
   logic [WIDTH-1:0] res1;

   assign a_sgn  = (in_mode == MODE_XSS) || (in_mode == MODE_XSU);
   assign b_sgn  = (in_mode == MODE_XSS);
   assign p1_d   = half_mul(in_src1[HALF-1:0], 1'b0, in_src2[HALF-1:0], 1'b0);
   assign p2_d   = half_mul(in_src1[HALF-1:0], 1'b0, in_src2[WIDTH-1:HALF], b_sgn);
   assign p3_d   = half_mul(in_src1[WIDTH-1:HALF], a_sgn, in_src2[HALF-1:0], 1'b0);
   assign p4_d   = half_mul(in_src1[WIDTH-1:HALF], a_sgn, in_src2[WIDTH-1:HALF], b_sgn);
   assign in_ready = ~flush & ld1;
   assign accept   = in_valid & in_ready;
   assign res1     = sel_result(p1_q, p2_q, p3_q, p4_q, mode1_q);

   // Stage 1: partial products, mode, tag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         v1_q    <= 1'b0;
         p1_q    <= '0;
         p2_q    <= '0;
         p3_q    <= '0;
         p4_q    <= '0;
         mode1_q <= '0;
         tag1_q  <= '0;
      end else begin
         if (flush) v1_q <= 1'b0;
         else if (ld1) v1_q <= in_valid;
         if (accept) begin
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            p4_q    <= p4_d;
            mode1_q <= in_mode;
            tag1_q  <= in_tag;
         end
      end
   end

   if (PIPE == 2) begin : g_pipe2
      logic             ld2;
      logic             v2_q;
      logic [WIDTH-1:0] res2_q;
      logic [TAG_W-1:0] tag2_q;

      assign ld2 = ~v2_q | out_ready;
      assign ld1 = ~v1_q | ld2;

      // Stage 2: selected result half and tag
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            v2_q   <= 1'b0;
            res2_q <= '0;
            tag2_q <= '0;
         end else begin
            if (flush) v2_q <= 1'b0;
            else if (ld2) v2_q <= v1_q;
            if (ld2 && v1_q) begin
               res2_q <= res1;
               tag2_q <= tag1_q;
            end
         end
      end

      assign out_valid  = v2_q;
      assign out_result = res2_q;
      assign out_tag    = tag2_q;
      assign out_busy   = v1_q | v2_q;
   end else begin : g_pipe1
      assign ld1        = ~v1_q | out_ready;
      assign out_valid  = v1_q;
      assign out_result = res1;
      assign out_tag    = tag1_q;
      assign out_busy   = v1_q;
   end

endmodule

// File: tb/tb_nios2_mul_pipe.sv
// Bench for nios2_mul_pipe: directed vectors and corner sequences on 32-bit PIPE=2/1 instances,
// then randomized traffic on several widths against a full-width arithmetic reference.
module tb_nios2_mul_pipe;
   localparam int NCFG = 5;
   localparam int CW [NCFG] = '{8, 16, 32, 64, 32};
   localparam int CP [NCFG] = '{2, 2, 2, 2, 1};
   localparam int RND_CYC = 12000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;
   int   n_vec = 0;
   int   n_err = 0;

   // Directed instances share inputs
   logic        d_flush, d_in_valid, d_out_ready;
   logic [1:0]  d_mode;
   logic [31:0] d_src1, d_src2;
   logic [4:0]  d_tag;
   logic        d_in_ready, d_out_valid, d_busy;
   logic [31:0] d_res;
   logic [4:0]  d_otag;
   logic        e_in_ready, e_out_valid, e_busy;
   logic [31:0] e_res;
   logic [4:0]  e_otag;

   nios2_mul_pipe #(.WIDTH(32), .PIPE(2), .TAG_W(5)) u_dut (
      .clk(clk), .reset_n(reset_n), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
      .in_mode(d_mode), .in_src1(d_src1), .in_src2(d_src2), .in_tag(d_tag),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_result(d_res), .out_tag(d_otag),
      .out_busy(d_busy));

   nios2_mul_pipe #(.WIDTH(32), .PIPE(1), .TAG_W(5)) u_dut_p1 (
      .clk(clk), .reset_n(reset_n), .flush(d_flush), .in_valid(d_in_valid), .in_ready(e_in_ready),
      .in_mode(d_mode), .in_src1(d_src1), .in_src2(d_src2), .in_tag(d_tag),
      .out_valid(e_out_valid), .out_ready(d_out_ready), .out_result(e_res), .out_tag(e_otag),
      .out_busy(e_busy));

   // Randomized instances
   logic [NCFG-1:0]        r_flush, r_ivalid, r_oready, r_iready, r_ovalid, r_busy;
   logic [NCFG-1:0][1:0]   r_mode;
   logic [NCFG-1:0][63:0]  r_src1, r_src2, r_res;
   logic [NCFG-1:0][4:0]   r_tag, r_otag;

   for (genvar gi = 0; gi < NCFG; gi++) begin : g_rnd
      localparam int W = CW[gi];
      logic [W-1:0] res;
      nios2_mul_pipe #(.WIDTH(W), .PIPE(CP[gi]), .TAG_W(5)) u_dut (
         .clk(clk), .reset_n(reset_n), .flush(r_flush[gi]), .in_valid(r_ivalid[gi]),
         .in_ready(r_iready[gi]), .in_mode(r_mode[gi]), .in_src1(r_src1[gi][W-1:0]),
         .in_src2(r_src2[gi][W-1:0]), .in_tag(r_tag[gi]), .out_valid(r_ovalid[gi]),
         .out_ready(r_oready[gi]), .out_result(res), .out_tag(r_otag[gi]), .out_busy(r_busy[gi]));
      assign r_res[gi] = 64'(res);
   end

   typedef struct packed {
      logic [1:0]  mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   typedef struct packed {
      logic [63:0] res;
      logic [4:0]  tag;
   } exp_t;

   vec_t tbl [12];
   exp_t rq [NCFG][$];

   // Reference: extend operands to 128 bits by signedness, multiply, pick the half.
   function automatic logic [63:0] ref_mul(input int w, input logic [1:0] mode,
                                           input logic [63:0] a, input logic [63:0] b);
      logic [127:0] mask, ax, bx, p;
      logic         a_s, b_s;
      a_s  = (mode == 2'b01) || (mode == 2'b10);
      b_s  = (mode == 2'b01);
      mask = (128'd1 << w) - 128'd1;
      ax   = 128'(a) & mask;
      bx   = 128'(b) & mask;
      if (a_s && ax[w-1]) ax = ax | ~mask;
      if (b_s && bx[w-1]) bx = bx | ~mask;
      p = ax * bx;
      if (mode == 2'b00) return 64'(p & mask);
      return 64'((p >> w) & mask);
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_op(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tg);
      d_in_valid = 1'b1;
      d_mode     = m;
      d_src1     = a;
      d_src2     = b;
      d_tag      = tg;
   endtask

   task automatic run_vec(input string nm, input vec_t v, input logic [4:0] tg);
      int lat;
      @(negedge clk);
      set_op(v.mode, v.a, v.b, tg);
      d_out_ready = 1'b1;
      #1 chk({nm, " in_ready"}, 64'(d_in_ready), 64'd1);
      @(negedge clk);
      d_in_valid = 1'b0;
      lat = 1;
      while (!d_out_valid && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({nm, " latency"}, 64'(lat), 64'd2);
      chk({nm, " result"}, 64'(d_res), 64'(v.exp));
      chk({nm, " tag"}, 64'(d_otag), 64'(tg));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [4:0]  got_tag [$];
      logic [31:0] got_res [$];
      bit          acc;

      tbl[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE};
      tbl[1]  = '{2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001};
      tbl[2]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
      tbl[3]  = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
      tbl[4]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
      tbl[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000};
      tbl[6]  = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
      tbl[7]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
      tbl[8]  = '{2'b10, 32'h7FFFFFFF, 32'h80000000, 32'h3FFFFFFF};
      tbl[9]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
      tbl[10] = '{2'b00, 32'h00000003, 32'h00000005, 32'h0000000F};
      tbl[11] = '{2'b11, 32'h00010000, 32'h00010000, 32'h00000001};

      reset_n = 1'b0;
      d_flush = 1'b0; d_in_valid = 1'b0; d_out_ready = 1'b0;
      d_mode = '0; d_src1 = '0; d_src2 = '0; d_tag = '0;
      r_flush = '0; r_ivalid = '0; r_oready = '0; r_mode = '0;
      r_src1 = '0; r_src2 = '0; r_tag = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset out_valid", 64'(d_out_valid), 64'd0);
      chk("reset out_result", 64'(d_res), 64'd0);
      chk("reset out_tag", 64'(d_otag), 64'd0);
      chk("reset out_busy", 64'(d_busy), 64'd0);
      reset_n = 1'b1;
      #1 chk("post-reset in_ready", 64'(d_in_ready), 64'd1);

      for (int i = 0; i < 12; i++)
         run_vec($sformatf("vec%0d", i), tbl[i], 5'(i + 1));

      // Streaming: 4 back-to-back ops, latency 2 (PIPE=2) and 1 (PIPE=1)
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i < 4) set_op(2'b00, 32'(i + 1), 32'd10, 5'(i + 1));
         else d_in_valid = 1'b0;
         d_out_ready = 1'b1;
         #1;
         chk($sformatf("stream p2 valid c%0d", i), 64'(d_out_valid), 64'(i >= 2 && i <= 5));
         if (i >= 2 && i <= 5) begin
            chk($sformatf("stream p2 tag c%0d", i), 64'(d_otag), 64'(i - 1));
            chk($sformatf("stream p2 result c%0d", i), 64'(d_res), 64'((i - 1) * 10));
         end
         chk($sformatf("stream p1 valid c%0d", i), 64'(e_out_valid), 64'(i >= 1 && i <= 4));
         if (i >= 1 && i <= 4) chk($sformatf("stream p1 tag c%0d", i), 64'(e_otag), 64'(i));
      end

      // Backpressure: two accepted, third held off, then drained in order
      @(negedge clk);
      set_op(2'b00, 32'd11, 32'd3, 5'd11);
      d_out_ready = 1'b0;
      #1 chk("bp in_ready op1", 64'(d_in_ready), 64'd1);
      @(negedge clk);
      set_op(2'b00, 32'd12, 32'd3, 5'd12);
      #1 chk("bp in_ready op2", 64'(d_in_ready), 64'd1);
      @(negedge clk);
      set_op(2'b00, 32'd13, 32'd3, 5'd13);
      #1 chk("bp in_ready op3 full", 64'(d_in_ready), 64'd0);
      repeat (2) begin
         @(negedge clk);
         #1;
         chk("bp hold in_ready", 64'(d_in_ready), 64'd0);
         chk("bp hold out_valid", 64'(d_out_valid), 64'd1);
         chk("bp hold tag", 64'(d_otag), 64'd11);
         chk("bp hold result", 64'(d_res), 64'd33);
      end
      acc = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (acc) d_in_valid = 1'b0;
         d_out_ready = 1'b1;
         #1;
         if (c == 0) chk("bp release in_ready", 64'(d_in_ready), 64'd1);
         acc = d_in_valid && d_in_ready;
         if (d_out_valid && d_out_ready) begin
            got_tag.push_back(d_otag);
            got_res.push_back(d_res);
         end
      end
      d_in_valid = 1'b0;
      chk("bp delivered count", 64'(got_tag.size()), 64'd3);
      for (int k = 0; k < 3 && k < got_tag.size(); k++) begin
         chk($sformatf("bp order tag%0d", k), 64'(got_tag[k]), 64'(11 + k));
         chk($sformatf("bp order result%0d", k), 64'(got_res[k]), 64'(3 * (11 + k)));
      end

      // Flush with two ops in flight
      @(negedge clk);
      set_op(2'b00, 32'd2, 32'd2, 5'd5);
      d_out_ready = 1'b0;
      @(negedge clk);
      set_op(2'b00, 32'd2, 32'd3, 5'd6);
      @(negedge clk);
      set_op(2'b00, 32'd2, 32'd4, 5'd7);
      d_out_ready = 1'b1;
      d_flush = 1'b1;
      #1;
      chk("flush in_ready", 64'(d_in_ready), 64'd0);
      chk("flush busy before", 64'(d_busy), 64'd1);
      @(negedge clk);
      d_flush = 1'b0;
      d_in_valid = 1'b0;
      #1;
      chk("flush out_valid after", 64'(d_out_valid), 64'd0);
      chk("flush out_busy after", 64'(d_busy), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("flush nothing delivered c%0d", c), 64'(d_out_valid), 64'd0);
      end
      run_vec("post-flush", '{2'b00, 32'd7, 32'd6, 32'd42}, 5'd8);

      // Asynchronous reset mid-stream
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         set_op(2'b00, 32'd9, 32'(k + 1), 5'(20 + k));
         d_out_ready = 1'b1;
      end
      @(negedge clk);
      d_in_valid = 1'b0;
      #1 chk("pre-reset out_valid", 64'(d_out_valid), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("async reset out_valid", 64'(d_out_valid), 64'd0);
      chk("async reset out_result", 64'(d_res), 64'd0);
      chk("async reset out_tag", 64'(d_otag), 64'd0);
      chk("async reset out_busy", 64'(d_busy), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      run_vec("post-reset", '{2'b00, 32'd3, 32'd5, 32'd15}, 5'd9);
      @(negedge clk);
      d_out_ready = 1'b0;

      // Randomized traffic on all widths
      for (int cyc = 0; cyc < RND_CYC; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < NCFG; i++) begin
            logic [63:0] op [2];
            for (int j = 0; j < 2; j++) begin
               case ($urandom_range(0, 7))
                  0: op[j] = '0;
                  1: op[j] = '1;
                  2: op[j] = 64'd1 << (CW[i] - 1);
                  default: op[j] = {$urandom, $urandom};
               endcase
            end
            r_ivalid[i] = ($urandom_range(0, 3) != 0);
            r_oready[i] = ($urandom_range(0, 3) != 0);
            r_flush[i]  = ($urandom_range(0, 49) == 0);
            r_mode[i]   = 2'($urandom_range(0, 3));
            r_tag[i]    = 5'($urandom);
            r_src1[i]   = op[0];
            r_src2[i]   = op[1];
         end
         #1;
         for (int i = 0; i < NCFG; i++) begin
            int   cnt;
            exp_t e;
            cnt = rq[i].size();
            chk($sformatf("rnd cfg%0d in_ready", i), 64'(r_iready[i]),
                64'(!r_flush[i] && (cnt < CP[i] || r_oready[i])));
            chk($sformatf("rnd cfg%0d out_busy", i), 64'(r_busy[i]), 64'(cnt != 0));
            chk($sformatf("rnd cfg%0d out_valid without op", i), 64'(r_ovalid[i] && cnt == 0), 64'd0);
            if (r_flush[i]) begin
               rq[i].delete();
            end else begin
               if (r_ovalid[i] && r_oready[i] && cnt > 0) begin
                  e = rq[i].pop_front();
                  chk($sformatf("rnd cfg%0d result", i), r_res[i], e.res);
                  chk($sformatf("rnd cfg%0d tag", i), 64'(r_otag[i]), 64'(e.tag));
               end
               if (r_ivalid[i] && r_iready[i])
                  rq[i].push_back('{ref_mul(CW[i], r_mode[i], r_src1[i], r_src2[i]), r_tag[i]});
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
